// File: rtl/multi_mode_reg_pkg.sv
// Shared mode encodings for the multi-mode storage/shift/count register.
package multi_mode_reg_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        LOAD = 3'b001,
        SHR  = 3'b010,
        SHL  = 3'b011,
        ROR  = 3'b100,
        ROL  = 3'b101,
        UP   = 3'b110,
        DN   = 3'b111
    } mode_e;

    localparam int MODE_W = 3;

endpackage

// File: rtl/multi_mode_reg_if.sv
// Control/data bundle between the datapath driver (master) and the register (slave).
interface multi_mode_reg_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SIR;
    logic             SIL;
    logic [WIDTH-1:0] Q;
    logic             SOR;
    logic             SOL;
    logic             TC;

    modport master (
        output EN, MODE, D, SIR, SIL,
        input  Q, SOR, SOL, TC
    );

    modport slave (
        input  EN, MODE, D, SIR, SIL,
        output Q, SOR, SOL, TC
    );
endinterface

// File: rtl/mmr_next_state.sv
// Combinational next-Q for every mode.
// Counting saturates instead of wrapping when MULTI_MODE_REG_SAT_EN is defined.
module mmr_next_state
    import multi_mode_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  mode_e            mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sir_i,
    input  logic             sil_i,
    output logic [WIDTH-1:0] q_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic all_ones;
    logic all_zero;

    assign all_ones = &q_i;
    assign all_zero = ~|q_i;

    always_comb begin
        q_o = q_i;
        unique case (mode_i)
            HOLD: q_o = q_i;
            LOAD: q_o = d_i;
            SHR:  q_o = {sir_i, q_i[WIDTH-1:1]};
            SHL:  q_o = {q_i[WIDTH-2:0], sil_i};
            ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
            ROL:  q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
`ifdef MULTI_MODE_REG_SAT_EN
            UP:   q_o = all_ones ? q_i : q_i + ONE;
            DN:   q_o = all_zero ? q_i : q_i - ONE;
`else
            UP:   q_o = q_i + ONE;
            DN:   q_o = q_i - ONE;
`endif
        endcase
    end

    // both flags are only consumed by the saturating build
    logic unused_flags;
    assign unused_flags = all_ones ^ all_zero;

endmodule

// File: rtl/multi_mode_reg.sv
// Multi-mode N-bit register: flop, enable, async clear and terminal count.
// Optional saturating counter via MULTI_MODE_REG_SAT_EN.
module multi_mode_reg
    import multi_mode_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic            CLK,
    input  logic            CLRn,
    multi_mode_reg_if.slave bus
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_nxt;
    mode_e            mode;

    assign mode = mode_e'(bus.MODE);

    mmr_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .q_i    (q_q),
        .mode_i (mode),
        .d_i    (bus.D),
        .sir_i  (bus.SIR),
        .sil_i  (bus.SIL),
        .q_o    (q_nxt)
    );

    assign q_d = bus.EN ? q_nxt : q_q;

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q   = q_q;
    assign bus.SOR = q_q[0];
    assign bus.SOL = q_q[WIDTH-1];

    // flags that the coming edge wraps (or saturates)
    assign bus.TC = bus.EN & (((mode == UP) & (&q_q)) |
                              ((mode == DN) & (~|q_q)));

endmodule

// File: tb/tb_multi_mode_reg.sv
// Scoreboard bench for multi_mode_reg (WIDTH=8, RST_VAL=8'hA5).
module tb_multi_mode_reg;
    import multi_mode_reg_pkg::*;

    localparam logic [7:0] RV = 8'hA5;
`ifdef MULTI_MODE_REG_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [7:0] q;
        logic       tc;
        string      name;
    } exp_t;

    logic CLK;
    logic CLRn;
    int   total;
    int   bad;
    exp_t sb[$];

    multi_mode_reg_if #(.WIDTH(8)) bus ();

    multi_mode_reg #(
        .WIDTH   (8),
        .RST_VAL (RV)
    ) dut (
        .CLK  (CLK),
        .CLRn (CLRn),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [7:0] ref_next(logic [7:0] q, logic [2:0] m,
                                            logic [7:0] d, logic sr, logic sl);
        case (m)
            3'd0: return q;
            3'd1: return d;
            3'd2: return {sr, q[7:1]};
            3'd3: return {q[6:0], sl};
            3'd4: return {q[0], q[7:1]};
            3'd5: return {q[6:0], q[7]};
            3'd6: return (SAT && q == 8'hFF) ? q : q + 8'd1;
            default: return (SAT && q == 8'h00) ? q : q - 8'd1;
        endcase
    endfunction

    function automatic logic ref_tc(logic [7:0] q, logic en, logic [2:0] m);
        return en && ((m == 3'd6 && q == 8'hFF) || (m == 3'd7 && q == 8'h00));
    endfunction

    // monitor: register output is always presented, sampled mid-cycle
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (bus.Q !== e.q || bus.TC !== e.tc ||
                bus.SOR !== e.q[0] || bus.SOL !== e.q[7]) begin
                bad++;
                $display("FAIL %s: got Q=%h TC=%b SOR=%b SOL=%b want Q=%h TC=%b SOR=%b SOL=%b",
                         e.name, bus.Q, bus.TC, bus.SOR, bus.SOL,
                         e.q, e.tc, e.q[0], e.q[7]);
            end
        end
    end

    // drive one cycle at posedge+1 and queue what the negedge must show
    task automatic step(input logic clr_n, input logic en, input logic [2:0] m,
                        input logic [7:0] d, input logic sr, input logic sl,
                        input logic [7:0] eq, input logic etc, input string nm);
        exp_t e;
        CLRn     = clr_n;
        bus.EN   = en;
        bus.MODE = m;
        bus.D    = d;
        bus.SIR  = sr;
        bus.SIL  = sl;
        e.q  = eq;
        e.tc = etc;
        e.name = nm;
        sb.push_back(e);
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] mq;
    logic       p_en, p_sr, p_sl, p_clr;
    logic [2:0] p_m;
    logic [7:0] p_d;

    initial begin
        total = 0;
        bad   = 0;
        CLRn  = 1'b0;
        bus.EN = 1'b0; bus.MODE = 3'd0; bus.D = 8'h00;
        bus.SIR = 1'b0; bus.SIL = 1'b0;
        @(posedge CLK);
        #1;

        step(1'b0, 1'b0, HOLD, 8'h00, 0, 0, RV, 1'b0, "reset");
        step(1'b1, 1'b1, LOAD, 8'h12, 0, 0, RV, 1'b0, "release");
        step(1'b0, 1'b1, LOAD, 8'h3C, 0, 0, RV, 1'b0, "clr_midcycle");
        step(1'b1, 1'b1, LOAD, 8'h3C, 0, 0, RV, 1'b0, "clr_held_edge");

        step(1'b1, 1'b1, LOAD, 8'h81, 0, 0, 8'h3C, 1'b0, "load_after_clr");
        step(1'b1, 1'b1, SHR,  8'h00, 1, 0, 8'h81, 1'b0, "load81");
        step(1'b1, 1'b1, SHR,  8'h00, 1, 0, 8'hC0, 1'b0, "shr1");
        step(1'b1, 1'b1, SHL,  8'h00, 0, 0, 8'hE0, 1'b0, "shr2");
        step(1'b1, 1'b1, LOAD, 8'h81, 0, 0, 8'hC0, 1'b0, "shl1");

        step(1'b1, 1'b1, ROL,  8'h00, 0, 0, 8'h81, 1'b0, "rot_load");
        step(1'b1, 1'b1, ROR,  8'h00, 0, 0, 8'h03, 1'b0, "rol1");
        step(1'b1, 1'b1, ROR,  8'h00, 0, 0, 8'h81, 1'b0, "ror1");
        step(1'b1, 1'b1, ROR,  8'h00, 0, 0, 8'hC0, 1'b0, "ror2");
        step(1'b1, 1'b1, ROR,  8'h00, 0, 0, 8'h60, 1'b0, "ror3");
        step(1'b1, 1'b1, ROR,  8'h00, 0, 0, 8'h30, 1'b0, "ror4");
        step(1'b1, 1'b1, ROR,  8'h00, 0, 0, 8'h18, 1'b0, "ror5");
        step(1'b1, 1'b1, ROR,  8'h00, 0, 0, 8'h0C, 1'b0, "ror6");
        step(1'b1, 1'b1, ROR,  8'h00, 0, 0, 8'h06, 1'b0, "ror7");

        step(1'b1, 1'b1, LOAD, 8'hFE, 0, 0, 8'h03, 1'b0, "ror8_full");
        step(1'b1, 1'b1, UP,   8'h00, 0, 0, 8'hFE, 1'b0, "up_fe");
        step(1'b1, 1'b1, UP,   8'h00, 0, 0, 8'hFF, 1'b1, "up_ff_tc");
        step(1'b1, 1'b1, UP,   8'h00, 0, 0, SAT ? 8'hFF : 8'h00,
             SAT, "up_wrap");
        step(1'b1, 1'b1, LOAD, 8'h01, 0, 0, SAT ? 8'hFF : 8'h01,
             1'b0, "up_after_wrap");
        step(1'b1, 1'b1, DN,   8'h00, 0, 0, 8'h01, 1'b0, "dn_01");
        step(1'b1, 1'b1, DN,   8'h00, 0, 0, 8'h00, 1'b1, "dn_00_tc");
        step(1'b1, 1'b1, LOAD, 8'hFF, 0, 0, SAT ? 8'h00 : 8'hFF,
             1'b0, "dn_wrap");

        step(1'b1, 1'b0, UP,   8'h00, 0, 0, 8'hFF, 1'b0, "en0_up_a");
        step(1'b1, 1'b0, UP,   8'h00, 0, 0, 8'hFF, 1'b0, "en0_up_b");
        step(1'b1, 1'b0, UP,   8'h00, 0, 0, 8'hFF, 1'b0, "en0_up_c");
        step(1'b1, 1'b0, LOAD, 8'h55, 0, 0, 8'hFF, 1'b0, "en0_load_a");
        step(1'b1, 1'b0, LOAD, 8'h55, 0, 0, 8'hFF, 1'b0, "en0_load_b");
        step(1'b1, 1'b1, UP,   8'h00, 0, 0, 8'hFF, 1'b1, "en1_up");
        step(1'b1, 1'b1, HOLD, 8'h00, 0, 0, SAT ? 8'hFF : 8'h00,
             1'b0, "resume");

        // random phase, starts from a clear held across one edge
        step(1'b0, 1'b1, UP, 8'h00, 0, 0, RV, 1'b0, "rnd_clr");
        mq = RV;
        p_clr = 1'b0;
        p_en = 1'b0; p_m = 3'd0; p_d = 8'h00; p_sr = 1'b0; p_sl = 1'b0;
        for (int i = 0; i < 200; i++) begin
            exp_t e;
            logic clr_low;
            logic rel;
            if (p_clr && p_en)
                mq = ref_next(mq, p_m, p_d, p_sr, p_sl);
            clr_low  = ($urandom_range(0, 9) == 0);
            rel      = $urandom_range(0, 1) == 1;
            p_en     = $urandom_range(0, 3) != 0;
            p_m      = 3'($urandom_range(0, 7));
            p_d      = 8'($urandom);
            p_sr     = 1'($urandom);
            p_sl     = 1'($urandom);
            if (clr_low)
                mq = RV;
            CLRn     = ~clr_low;
            bus.EN   = p_en;
            bus.MODE = p_m;
            bus.D    = p_d;
            bus.SIR  = p_sr;
            bus.SIL  = p_sl;
            e.q  = mq;
            e.tc = ref_tc(mq, p_en, p_m);
            e.name = $sformatf("rnd%0d", i);
            sb.push_back(e);
            @(negedge CLK);
            #1;
            if (clr_low && rel)
                CLRn = 1'b1;
            p_clr = CLRn;
            @(posedge CLK);
            #1;
        end

        @(negedge CLK);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_mode_reg.md
Name: multi_mode_reg

Overview:
- Parametrised N-bit clocked register, the edge-triggered successor to the single-bit active-low-clear D latch.
- Eight operating modes: hold, parallel load, shift right/left, rotate right/left, count up/down.
- Provides serial outputs at both ends and a terminal-count flag.
- Used as the general storage/shift/count element in the lab datapaths.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- RST_VAL, 0, value forced onto Q by asynchronous clear (WIDTH bits, truncated).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLRn  input  1  asynchronous active-low clear; Q ← RST_VAL immediately while low.
- EN  input  1  synchronous enable; 0 forces hold regardless of MODE.
- MODE  input  3  operation select (encodings below).
- D  input  WIDTH  parallel load data.
- SIR  input  1  serial in for shift right (enters MSB).
- SIL  input  1  serial in for shift left (enters LSB).
- Q  output  WIDTH  register contents.
- SOR  output  1  equals Q[0].
- SOL  output  1  equals Q[WIDTH-1].
- TC  output  1  terminal count, combinational.

Behaviour:
- Reset
  - CLRn=0 asynchronously sets Q=RST_VAL; SOR/SOL/TC follow Q.
  - Reset mid-operation discards the operation in progress, with no partial update.
  - On the first rising CLK after CLRn deasserts, the register operates normally.
- Update rule: Q updates only on a rising CLK with CLRn=1 and EN=1. EN=0 means Q holds.
- MODE encodings (one clock latency for all):
  - 000 HOLD: Q unchanged.
  - 001 LOAD: Q ← D.
  - 010 SHR: Q ← {SIR, Q[WIDTH-1:1]}.
  - 011 SHL: Q ← {Q[WIDTH-2:0], SIL}.
  - 100 ROR: Q ← {Q[0], Q[WIDTH-1:1]}.
  - 101 ROL: Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 110 UP: Q ← Q+1 modulo 2^WIDTH; all-ones wraps to 0.
  - 111 DN: Q ← Q−1 modulo 2^WIDTH; 0 wraps to all-ones.
- Arithmetic is unsigned and WIDTH bits wide; carry/borrow is discarded.
- TC:
  - 1 when EN=1, MODE=UP and Q=all-ones.
  - 1 when EN=1, MODE=DN and Q=0.
  - 0 otherwise, including while CLRn=0 unless RST_VAL satisfies the condition above.
  - TC is combinational, so it flags that the next edge will wrap.
- SOR/SOL are combinational taps on Q, with no extra latency.
- Simultaneous events: CLRn=0 dominates CLK/EN/MODE. A MODE change takes effect on the next edge only.
- Decoding is full over all 8 MODE values; there is no illegal state.

Optional Feature:
- Macro: MULTI_MODE_REG_SAT_EN.
- Defined:
  - UP saturates at all-ones: Q stays all-ones, with no wrap.
  - DN saturates at 0.
  - TC still asserts under the same conditions, signalling saturation.
- Undefined: modulo wrap as specified above.
- Shift, rotate and load are unaffected either way.

Decomposition:
- Package multi_mode_reg_pkg:
  - MODE encoding constants: HOLD, LOAD, SHR, SHL, ROR, ROL, UP, DN.
  - Mode typedef (3-bit enum).
- Sub-module mmr_next_state:
  - Purely combinational next-Q computation from Q, MODE, D, SIR, SIL.
  - Parametrised by WIDTH.
  - Contains the SAT_EN conditional.
- The top level holds the flop, the enable, the clear and TC.

Test Plan:
1. Clear
   - WIDTH=8, RST_VAL=8'hA5, CLRn=0 mid-cycle with EN=1, MODE=LOAD, D=8'h3C → Q=8'hA5 immediately, with no clock edge needed.
   - Release CLRn, next edge → Q=8'h3C.
2. Shift/serial
   - Load 8'b1000_0001.
   - SHR with SIR=1 for 2 edges → Q=8'b1110_0000 and SOR=0.
   - SHL with SIL=0 for 1 edge → Q=8'b1100_0000 and SOL=1.
3. Rotate
   - Load 8'h81.
   - ROL 1 edge → 8'h03.
   - ROR 2 edges → 8'hC0.
   - ROR 6 more edges → 8'h03 (full circulation after WIDTH rotates).
4. Count wrap
   - Load 8'hFE.
   - UP: TC=0, then edge → 8'hFF and TC=1, then edge → 8'h00 (8'hFF with SAT_EN) and TC=0 (TC=1 with SAT_EN).
   - Load 8'h01.
   - DN: edge → 8'h00 and TC=1, then edge → 8'hFF (8'h00 with SAT_EN).
5. Enable
   - EN=0 with MODE=UP/LOAD for 5 edges → Q unchanged and TC=0.
   - EN=1 → counting resumes on the next edge.
6. Random
   - 200 cycles of random EN/MODE/D/SIR/SIL/CLRn, checked against a reference model each edge.
   - Also checks CLRn pulses asserting and deasserting between edges.
